// File: rtl/mux_rr_arbiter.sv
// Packet-granular round-robin arbiter that steers one 2:1 mux between sources A and B
// onto a single valid/ready sink, with a per-grant beat limit that forces release.
//
// state | meaning
// IDLE  | no grant; arbitrate every cycle on a_valid/b_valid
// GNT_A | source A owns the sink until its last beat or the beat limit
// GNT_B | source B owns the sink until its last beat or the beat limit
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             s,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    state_t     state;
    logic       prio;
    logic [7:0] beat_cnt;

    logic gnt_valid;
    logic gnt_last;
    logic accept;
    logic decide;
    logic any_valid;
    logic pick_b;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        case (state)
            GNT_A: begin
                gnt_valid = a_valid;
                gnt_last  = a_last;
            end
            GNT_B: begin
                gnt_valid = b_valid;
                gnt_last  = b_last;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign y_valid = gnt_valid;
    assign y_data  = s ? b_data : a_data;
    assign y_last  = busy & (gnt_last | (beat_cnt == LAST_CNT));
    assign a_ready = (state == GNT_A) & y_ready;
    assign b_ready = (state == GNT_B) & y_ready;

    assign accept    = y_valid & y_ready;
    assign decide    = (state == IDLE) | (accept & y_last);
    assign any_valid = a_valid | b_valid;
    // B wins when it is the only requester, or when both request and prio points at B
    assign pick_b    = b_valid & (prio | ~a_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= 1'b0;
            prio     <= 1'b0;
            beat_cnt <= 8'd0;
        end else if (decide) begin
            beat_cnt <= 8'd0;
            if (any_valid) begin
                state <= pick_b ? GNT_B : GNT_A;
                s     <= pick_b;
                prio  <= ~pick_b;
            end else begin
                state <= IDLE;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one 2:1 data mux between two packet sources, A and B, feeding a single downstream sink.
- Round-robin arbitration at packet granularity.
- Drives the mux select, gates valid/ready through the mux, and bounds every grant with a beat limit.
- Sits between two producer channels and one consumer channel. Valid/ready on all three channels.

Parameters:
- WIDTH, 8, data width of each channel
- MAX_BEATS, 16, maximum beats per grant before forced release (1..255)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  source A beat valid
- a_data  input  WIDTH  source A data
- a_last  input  1  source A final beat of packet
- a_ready  output  1  source A beat accepted
- b_valid  input  1  source B beat valid
- b_data  input  WIDTH  source B data
- b_last  input  1  source B final beat of packet
- b_ready  output  1  source B beat accepted
- y_valid  output  1  sink beat valid
- y_data  output  WIDTH  sink data (mux output)
- y_last  output  1  sink final beat (last of packet, or forced-release beat)
- y_ready  input  1  sink can accept
- s  output  1  registered mux select (0=A, 1=B)
- busy  output  1  a grant is active

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- State machine: IDLE, GNT_A, GNT_B. Registers: state, s, prio (1-bit round-robin pointer, 0 = A preferred), beat_cnt.
- Reset values:
  - state=IDLE, s=0, prio=0, beat_cnt=0, busy=0.
  - Combinational outputs at reset: y_valid=0, a_ready=0, b_ready=0, y_last=0, y_data=a_data (s=0).
- Datapath:
  - y_data = s ? b_data : a_data, combinational.
  - y_valid = granted source valid (0 in IDLE).
  - granted source ready = y_ready; non-granted ready = 0; both readies 0 in IDLE.
  - y_last = granted source last OR (beat_cnt == MAX_BEATS-1).
- Beat and release rules:
  - A beat is accepted when y_valid & y_ready.
  - beat_cnt increments per accepted beat and clears on every grant change or release.
  - Release occurs on an accepted beat with y_last=1.
- Arbitration:
  - A decision is made in IDLE, or on the release cycle. The new grant takes effect the next cycle.
  - Candidates are sources with valid=1.
  - If both are valid, the source indicated by prio wins.
  - If one is valid, that source wins, even if it was just served.
  - If none is valid, go to IDLE.
  - On the release cycle, the releasing source's own valid is evaluated. This permits back-to-back packets from one source when the other is idle.
- Round-robin: on every grant to X, prio is set to point at the other source.
- Latency:
  - IDLE -> first beat transferable 1 cycle after valid is seen.
  - Release -> next grant has no bubble: the new grant is active in the cycle after the last beat.
- s is updated only on grant entry. s holds its value in IDLE.
- busy=1 in GNT_A/GNT_B.
- Valid withdrawal is a protocol violation: if the granted source deasserts valid mid-packet, the grant is held (no timeout).
- Simultaneous events: a last beat and a new request from the other source in the same cycle -> release plus grant to the other source, effective next cycle.
- Async reset mid-packet: immediately return to IDLE, s=0, prio=0, all readies 0; the partial packet is abandoned.
- MAX_BEATS=1: every beat is a forced release; sources alternate per beat when both are requesting.

Test Plan:
- Reset with a_valid=1, rst_n low → a_ready=0, y_valid=0, s=0. First cycle after rst_n rises: IDLE sees a_valid. Next cycle: s=0, busy=1, a beat passes with y_data=a_data.
- Both valid from IDLE, prio=0, A sends 3-beat packet (0x11,0x22,0x33 last), B pending → A's three beats appear on y; B granted the cycle after 0x33, s=1, no bubble.
- Only B valid, two consecutive 2-beat packets → B re-granted back-to-back, s stays 1, four consecutive beats with y_ready=1.
- A sends 20-beat packet with MAX_BEATS=16, B valid → y_last=1 on beat 16, grant moves to B. After B's packet ends, A is re-granted and beats 17-20 resume.
- y_ready held 0 for 5 cycles mid-packet → y_data and s stable, beat_cnt unchanged, a_ready=0 throughout.
- rst_n pulsed low at beat 2 of a B packet → busy drops immediately, s=0. After release, A (valid) is granted first because prio=0.
